// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared constants, IFU state encoding and PC helper
package npc_pkg;

    localparam int          INST_W           = 32;
    localparam int          PC_W             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        IFU_REQ  = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_DROP = 2'd2
    } ifu_state_t;

    // Fetch addresses are always word aligned; low bits of a target are dropped.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - instruction buffer with push/pop/flush and occupancy count
module ifu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A push into a full buffer is only legal when the head leaves in the same edge.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: single-outstanding fetch FSM, PC and redirect handling
module ifu
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [PC_W-1:0]   mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [INST_W-1:0] mem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc
);

    localparam int CW = ((BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1) + 1;

    ifu_state_t              state;
    ifu_state_t              state_nxt;
    logic [PC_W-1:0]         fetch_pc;
    logic [PC_W-1:0]         fetch_pc_nxt;
    logic [PC_W-1:0]         inflight_pc;
    logic [PC_W-1:0]         inflight_pc_nxt;
    logic [PC_W-1:0]         redirect_target;

    logic [CW-1:0]           occ;
    logic                    buf_full;
    logic                    buf_empty;
    logic                    buf_push;
    logic                    buf_pop;
    logic [PC_W+INST_W-1:0]  buf_head;
    logic                    has_room;
    logic                    req_fire;

    assign redirect_target = align_pc(redirect_pc);

    // Requests only issue from REQ, where nothing is outstanding, so occupancy
    // alone already accounts for the request about to go out.
    assign has_room      = (occ < CW'(BUF_DEPTH));
    assign mem_req_valid = !rst && (state == IFU_REQ) && has_room;
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign inst_valid = !buf_empty && !redirect_valid;
    assign buf_pop    = inst_valid && inst_ready;
    assign buf_push   = (state == IFU_WAIT) && mem_resp_valid && !redirect_valid
                        && (!buf_full || buf_pop);

    assign inst    = buf_head[INST_W-1:0];
    assign inst_pc = buf_head[PC_W+INST_W-1:INST_W];

    always_comb begin
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        inflight_pc_nxt = inflight_pc;
        case (state)
            IFU_REQ: begin
                if (req_fire) begin
                    inflight_pc_nxt = fetch_pc;
                    fetch_pc_nxt    = fetch_pc + 32'd4;
                    state_nxt       = redirect_valid ? IFU_DROP : IFU_WAIT;
                end
            end
            IFU_WAIT: begin
                if (mem_resp_valid) begin
                    state_nxt = IFU_REQ;
                end else if (redirect_valid) begin
                    state_nxt = IFU_DROP;
                end
            end
            IFU_DROP: begin
                if (mem_resp_valid) begin
                    state_nxt = IFU_REQ;
                end
            end
            default: begin
                state_nxt = IFU_REQ;
            end
        endcase
        // A redirect always wins over the sequential increment.
        if (redirect_valid) begin
            fetch_pc_nxt = redirect_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IFU_REQ;
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            inflight_pc <= inflight_pc_nxt;
        end
    end

    ifu_fifo #(
        .WIDTH (PC_W + INST_W),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data ({inflight_pc, mem_resp_data}),
        .pop       (buf_pop),
        .flush     (redirect_valid),
        .pop_data  (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (occ)
    );

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - self-checking bench for ifu with memory model and fetch-stream reference
module tb_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    always #5 clk = ~clk;

    ifu #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: outstanding request, live responses in the buffer, stream PCs.
    bit          pending;
    bit          live;
    bit          spur_en = 1'b0;
    int          pend_lat;
    int          occ;
    int          delivered;
    logic [31:0] pend_addr;
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;
    logic [31:0] acc_q[$];
    logic [31:0] del_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        pending   = 1'b0;
        live      = 1'b0;
        pend_lat  = 0;
        occ       = 0;
        delivered = 0;
        exp_fetch = RST_PC;
        exp_pc    = RST_PC;
        acc_q.delete();
        del_q.delete();
    endtask

    task automatic cycle(input bit rdy, input bit irdy, input bit rv,
                         input logic [31:0] rpc, input int lat);
        bit resp;
        bit accept;
        bit deq;
        @(negedge clk);
        mem_req_ready  = rdy;
        inst_ready     = irdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        resp           = pending && (pend_lat == 0);
        mem_resp_valid = resp || (spur_en && !pending && ($urandom_range(0, 9) == 0));
        mem_resp_data  = resp ? mem_word(pend_addr) : $urandom();
        #1;
        check("mem_req_valid", 32'(mem_req_valid), 32'(!pending && (occ < DEPTH)));
        if (mem_req_valid) check("mem_req_addr", mem_req_addr, exp_fetch);
        check("inst_valid", 32'(inst_valid), 32'((occ > 0) && !rv));
        if (inst_valid) begin
            check("inst_pc", inst_pc, exp_pc);
            check("inst", inst, mem_word(exp_pc));
        end
        accept = mem_req_valid && rdy;
        deq    = inst_valid && irdy;
        if (deq) begin
            occ--;
            del_q.push_back(exp_pc);
            exp_pc += 32'd4;
            delivered++;
        end
        if (pending) begin
            if (resp) begin
                if (live && !rv) occ++;
                pending = 1'b0;
            end else begin
                pend_lat--;
            end
        end
        if (accept) begin
            acc_q.push_back(mem_req_addr);
            pending   = 1'b1;
            live      = !rv;
            pend_addr = mem_req_addr;
            pend_lat  = lat;
            exp_fetch += 32'd4;
        end
        if (rv) begin
            occ       = 0;
            live      = 1'b0;
            exp_fetch = {rpc[31:2], 2'b00};
            exp_pc    = exp_fetch;
        end
    endtask

    // Reset is raised between clock edges so its effect must be immediate.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst            = 1'b1;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("first_req_valid", 32'(mem_req_valid), 32'd1);
        check("first_req_addr", mem_req_addr, RST_PC);
    endtask

    initial begin
        model_reset();
        #2;
        check("init_req_valid", 32'(mem_req_valid), 32'd0);
        check("init_inst_valid", 32'(inst_valid), 32'd0);
        do_reset();

        // Streaming with an always-ready, single-cycle memory.
        repeat (20) cycle(1'b1, 1'b1, 1'b0, 32'd0, 0);
        check("seq_addr0", acc_q[0], 32'h8000_0000);
        check("seq_addr1", acc_q[1], 32'h8000_0004);
        check("seq_addr2", acc_q[2], 32'h8000_0008);
        check("throughput", 32'(delivered), 32'd9);

        // Backpressure fills the buffer, then drains in order.
        do_reset();
        repeat (10) cycle(1'b1, 1'b0, 1'b0, 32'd0, 0);
        check("bp_req_valid", 32'(mem_req_valid), 32'd0);
        check("bp_inst_pc", inst_pc, 32'h8000_0000);
        check("bp_inst", inst, mem_word(32'h8000_0000));
        repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'd0, 0);
        check("drain0", del_q[0], 32'h8000_0000);
        check("drain1", del_q[1], 32'h8000_0004);
        check("drain2", del_q[2], 32'h8000_0008);

        // Redirect while waiting: stale response dropped.
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 32'd0, 2);
        cycle(1'b0, 1'b1, 1'b1, 32'h8000_0103, 0);
        repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'd0, 0);
        check("drop_next_addr", acc_q[1], 32'h8000_0100);
        check("drop_first_inst", del_q[0], 32'h8000_0100);

        // Redirect coincident with the response.
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 32'd0, 0);
        cycle(1'b1, 1'b1, 1'b1, 32'h8000_0103, 0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0, 0);
        check("coinc_req_count", 32'(acc_q.size()), 32'd2);
        check("coinc_next_addr", acc_q[1], 32'h8000_0100);

        // PC wrap at the top of the address space.
        do_reset();
        cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 0);
        repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'd0, 0);
        check("wrap_pc0", del_q[0], 32'hFFFF_FFFC);
        check("wrap_pc1", del_q[1], 32'h0000_0000);

        // Asynchronous reset while waiting with a buffered instruction.
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1);
        check("pre_rst_inst_valid", 32'(inst_valid), 32'd1);
        check("pre_rst_pending", 32'(pending), 32'd1);
        do_reset();

        // Randomized traffic with spurious responses and redirects.
        spur_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bit          rv;
            logic [31:0] rpc;
            rv  = ($urandom_range(0, 24) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, rv, rpc, $urandom_range(0, 3));
        end
        spur_en = 1'b0;
        check("random_progress", 32'(delivered > 200), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h80000000, the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, the instruction buffer entry count (power of two, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port mem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port mem_req_ready  input  1  memory accepts the request.
REQ-007 SHALL have port mem_req_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port mem_resp_valid  input  1  fetch data valid, exactly one per accepted request.
REQ-009 SHALL have port mem_resp_data  input  32  fetched instruction word.
REQ-010 SHALL have port inst_valid  output  1  buffered instruction available to the decode/execute stage.
REQ-011 SHALL have port inst_ready  input  1  downstream consumes the instruction.
REQ-012 SHALL have port inst  output  32  instruction at buffer head.
REQ-013 SHALL have port inst_pc  output  32  PC of inst.
REQ-014 SHALL have port redirect_valid  input  1  control-flow change (jal/jalr/branch/trap).
REQ-015 SHALL have port redirect_pc  input  32  new fetch target; bits [1:0] ignored (treated as 0).

Function
REQ-016 SHALL implement FSM states REQ (drive request), WAIT (one request outstanding), DROP (discard stale response).
REQ-017 SHALL keep at most one memory request outstanding.
REQ-018 In REQ, SHALL assert mem_req_valid only when buffer occupancy < BUF_DEPTH; mem_req_addr = fetch_pc, held stable until accepted.
REQ-019 On mem_req_valid & mem_req_ready, SHALL go to WAIT and record fetch_pc as the in-flight PC; fetch_pc += 4, wrapping at 2^32.
REQ-020 In WAIT on mem_resp_valid, SHALL enqueue {in-flight PC, mem_resp_data} and return to REQ in the same edge.
REQ-021 Buffer occupancy check SHALL count the outstanding request, so an enqueue never occurs when full.
REQ-022 Enqueued data SHALL appear on inst/inst_pc with inst_valid high the cycle after the response edge (no bypass).
REQ-023 inst_valid SHALL equal (buffer not empty) AND NOT redirect_valid; a dequeue occurs on inst_valid & inst_ready.
REQ-024 Simultaneous enqueue and dequeue SHALL leave occupancy unchanged and be legal when full.
REQ-025 inst/inst_pc SHALL hold their value while inst_valid & !inst_ready.
REQ-026 On redirect_valid, SHALL flush the buffer (occupancy 0) and set fetch_pc = {redirect_pc[31:2],2'b00} at that edge.
REQ-027 Redirect in REQ with no acceptance that cycle SHALL stay in REQ; the next request uses the new PC.
REQ-028 Redirect in REQ coinciding with request acceptance, or in WAIT without a response, SHALL go to DROP.
REQ-029 Redirect in WAIT coinciding with mem_resp_valid SHALL discard that response and go to REQ.
REQ-030 In DROP, SHALL deassert mem_req_valid, discard the next mem_resp_valid, then go to REQ; a further redirect in DROP only updates fetch_pc.
REQ-031 mem_resp_valid outside WAIT/DROP SHALL be ignored.

Reset
REQ-032 While rst is high, asynchronously: state=REQ, fetch_pc=RESET_PC, occupancy=0, mem_req_valid=0, inst_valid=0, inst=0, inst_pc=0.
REQ-033 First request (addr RESET_PC) SHALL be driven in the first cycle after rst deasserts.
REQ-034 Reset mid-transaction SHALL abandon the outstanding request; the memory model is reset by the same rst.

Structure
REQ-035 Shared package npc_pkg SHALL hold RESET_PC default, IFU state encoding, and the instruction width constant.
REQ-036 Buffer SHALL be sub-module ifu_fifo (width 64, depth BUF_DEPTH, push/pop/flush, full/empty/count); FSM and PC logic stay in ifu.

Verification
REQ-037 Reset release, memory always ready, 1-cycle response, inst_ready=1 -> addrs 80000000, 80000004, 80000008; inst_pc tracks; one inst per 2 cycles.
REQ-038 inst_ready=0 for 10 cycles -> occupancy reaches 2, mem_req_valid low, inst holds 80000000 word; release -> in-order drain, no loss/duplication.
REQ-039 Redirect to 80000103 in WAIT -> DROP, stale response not enqueued, next mem_req_addr=80000100.
REQ-040 Redirect coincident with mem_resp_valid -> response discarded, next request 80000100 in the following cycle, inst_valid low on redirect cycle.
REQ-041 Redirect to FFFFFFFC, then two fetches -> inst_pc FFFFFFFC then 00000000 (wrap).
REQ-042 rst asserted in WAIT with full buffer -> all outputs reset immediately (asynchronous); next request 80000000.
